// File: rtl/piso_pkg.sv
// rtl/piso_pkg.sv - shared FSM states, default sizes and clog2 helper for piso_rr_sched
//
// Purpose: common definitions imported by piso_rr_sched and rr_arbiter.
// Ports:   none (package).
package piso_pkg;

   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_SHIFT = 1'b1
   } state_t;

   localparam int DEF_WIDTH = 4;
   localparam int DEF_NREQ  = 4;

   // Ceiling log2, never below 1 so index and counter fields always exist.
   function automatic int clog2(input int n);
      int r;
      r = 0;
      while ((1 << r) < n) r++;
      if (r == 0) r = 1;
      return r;
   endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - combinational round-robin arbiter for piso_rr_sched
//
// Purpose: picks the first asserted request searching upward from ptr+1,
//          wrapping modulo NREQ.
// Ports:   req   - request vector
//          ptr   - index of the most recently granted requester
//          grant - one-hot (or zero) grant
//          idx   - encoded index of the granted requester
//          any   - at least one request is asserted
module rr_arbiter
   import piso_pkg::*;
#(
   parameter  int NREQ = DEF_NREQ,
   localparam int IDW  = clog2(NREQ)
) (
   input  logic [NREQ-1:0] req,
   input  logic [IDW-1:0]  ptr,
   output logic [NREQ-1:0] grant,
   output logic [IDW-1:0]  idx,
   output logic            any
);

   logic [IDW:0]   sum;
   logic [IDW-1:0] cand;

   always_comb begin
      grant = '0;
      idx   = '0;
      any   = 1'b0;
      sum   = '0;
      cand  = '0;
      for (int k = 1; k <= NREQ; k++) begin
         // One extra bit so ptr+k cannot overflow before the modulo wrap.
         sum = {1'b0, ptr} + (IDW+1)'(k);
         if (sum >= (IDW+1)'(NREQ)) sum = sum - (IDW+1)'(NREQ);
         cand = sum[IDW-1:0];
         if (!any && req[cand]) begin
            any         = 1'b1;
            grant[cand] = 1'b1;
            idx         = cand;
         end
      end
   end

endmodule

// File: rtl/piso_rr_sched.sv
// rtl/piso_rr_sched.sv - round-robin scheduler feeding one shared parallel-in/serial-out shifter
//
// Purpose: grants one of NREQ parallel requesters, loads its WIDTH-bit word and
//          streams it MSB-first with valid/ready flow control. One idle cycle
//          separates consecutive words.
// Option:  PISO_PARITY_EN - when defined, an even-parity bit (XOR of the word)
//          follows the data bits and carries last_o.
// Ports:   clk, rst     - clock, asynchronous active-high reset
//          req_valid_i  - per-requester word valid
//          req_data_i   - requester i word at [i*WIDTH +: WIDTH]
//          req_ready_o  - one-hot-or-zero accept strobe
//          ready_in     - downstream ready for the serial bit
//          data_o       - serial bit, MSB first
//          valid_out    - data_o is valid
//          first_o      - first bit of a word
//          last_o       - final bit of a word
//          grant_id_o   - requester owning the current word
module piso_rr_sched
   import piso_pkg::*;
#(
   parameter  int WIDTH = DEF_WIDTH,
   parameter  int NREQ  = DEF_NREQ,
   localparam int IDW   = clog2(NREQ)
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [NREQ-1:0]       req_valid_i,
   input  logic [NREQ*WIDTH-1:0] req_data_i,
   output logic [NREQ-1:0]       req_ready_o,
   input  logic                  ready_in,
   output logic                  data_o,
   output logic                  valid_out,
   output logic                  first_o,
   output logic                  last_o,
   output logic [IDW-1:0]        grant_id_o
);

`ifdef PISO_PARITY_EN
   localparam int NBITS = WIDTH + 1;
`else
   localparam int NBITS = WIDTH;
`endif
   localparam int CW = clog2(NBITS);

   state_t           state, state_nx;
   logic [NBITS-1:0] shreg;
   logic [CW-1:0]    count;
   logic [IDW-1:0]   ptr;
   logic [IDW-1:0]   grant_id;

   logic [NREQ-1:0]  grant;
   logic [IDW-1:0]   win_idx;
   logic             win_any;
   logic [WIDTH-1:0] win_word;
   logic [NBITS-1:0] load_val;
   logic             accept;
   logic             last_bit;

   rr_arbiter #(
      .NREQ (NREQ)
   ) u_arb (
      .req   (req_valid_i),
      .ptr   (ptr),
      .grant (grant),
      .idx   (win_idx),
      .any   (win_any)
   );

   // Grant is one-hot, so OR-ing the masked words selects the winner's word.
   always_comb begin
      win_word = '0;
      for (int i = 0; i < NREQ; i++) begin
         if (grant[i]) win_word = win_word | req_data_i[i*WIDTH +: WIDTH];
      end
   end

`ifdef PISO_PARITY_EN
   assign load_val = {win_word, ^win_word};
`else
   assign load_val = win_word;
`endif

   assign last_bit = (count == CW'(NBITS-1));

   always_comb begin
      state_nx    = state;
      req_ready_o = '0;
      accept      = 1'b0;
      case (state)
         ST_IDLE: begin
            // Gated by rst so every output is quiet while reset is held.
            req_ready_o = rst ? '0 : grant;
            accept      = win_any;
            if (win_any) state_nx = ST_SHIFT;
         end
         ST_SHIFT: begin
            if (ready_in && last_bit) state_nx = ST_IDLE;
         end
         default: state_nx = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= ST_IDLE;
      else     state <= state_nx;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         shreg    <= '0;
         count    <= '0;
         ptr      <= IDW'(NREQ-1);
         grant_id <= '0;
      end else if (accept) begin
         shreg    <= load_val;
         count    <= '0;
         ptr      <= win_idx;
         grant_id <= win_idx;
      end else if (state == ST_SHIFT && ready_in) begin
         shreg <= {shreg[NBITS-2:0], 1'b0};
         count <= last_bit ? '0 : count + CW'(1);
      end
   end

   assign valid_out  = (state == ST_SHIFT);
   assign data_o     = valid_out & shreg[NBITS-1];
   assign first_o    = valid_out & (count == '0);
   assign last_o     = valid_out & last_bit;
   assign grant_id_o = grant_id;

endmodule

// File: doc/piso_rr_sched.md
Name: piso_rr_sched

Overview:
Round-robin scheduler that shares one parallel-in/serial-out shifter among NREQ parallel requesters. Each requester presents a WIDTH-bit word with a valid/ready handshake. The block grants one requester, loads its word, and streams it MSB-first on a single serial output with valid/ready flow control. It sits between multiple parallel producers and one serial link, on the transmit clock domain.

Parameters:
- WIDTH, 4, bits per parallel word (>=2).
- NREQ, 4, number of requesters (>=2).
- IDW, $clog2(NREQ), width of grant index (derived, not overridden).

Ports:
- clk, input, 1, single clock, all state on posedge.
- rst, input, 1, asynchronous active-high reset.
- req_valid_i, input, NREQ, per-requester word valid.
- req_data_i, input, NREQ*WIDTH, requester i word at bits [i*WIDTH +: WIDTH].
- req_ready_o, output, NREQ, one-hot-or-zero accept strobe.
- ready_in, input, 1, downstream ready for the serial bit.
- data_o, output, 1, serial bit, MSB first.
- valid_out, output, 1, data_o is valid.
- first_o, output, 1, high with the first bit of a word.
- last_o, output, 1, high with the final bit of a word.
- grant_id_o, output, IDW, index of the requester owning the current word.

Behaviour:
- Reset (async, rst=1):
  - State is IDLE; shift register, bit counter and grant_id_o are 0.
  - Round-robin pointer is NREQ-1, so requester 0 has top priority first.
  - All outputs are 0 while reset is held.
- FSM states: IDLE, SHIFT.
- IDLE:
  - The winner is the first i with req_valid_i[i]=1, searching from pointer+1 upward with wrap modulo NREQ.
  - req_ready_o[winner] is asserted combinationally; all other bits are 0. If no requester is valid, req_ready_o=0.
  - On an edge where valid&ready: load the word into the shifter, set count=0, set pointer=winner, set grant_id_o=winner, go to SHIFT.
- SHIFT:
  - valid_out=1 and data_o=shreg[WIDTH-1].
  - first_o = (count==0); last_o = (count==WIDTH-1).
  - ready_in=1: shift left and increment count. If count==WIDTH-1, go to IDLE.
  - ready_in=0: data_o, count and flags hold.
  - req_ready_o=0 throughout SHIFT.
- Latency and throughput:
  - The first serial bit appears the cycle after acceptance.
  - Each word occupies WIDTH cycles with no stall, plus a mandatory one-cycle IDLE bubble, so back-to-back throughput is one word per WIDTH+1 cycles.
- Arbitration rules:
  - The pointer updates only on acceptance.
  - A requester that drops valid before being granted loses nothing.
  - The granted requester is always served before the same requester can be granted again, provided another requester is valid.
- Data changes on req_data_i are ignored after acceptance.
- Reset asserted mid-word aborts the word immediately: valid_out=0 and the pointer returns to NREQ-1. No partial word resumes.
- All-zero or all-one words are legal and need no special case.

Optional Feature:
- Macro: PISO_PARITY_EN.
- Defined:
  - An even-parity bit (XOR of the word) is sent after the WIDTH data bits, so a word takes WIDTH+1 serial cycles.
  - last_o is high on the parity bit, not on data bit WIDTH-1.
  - The parity bit obeys ready_in stalls like a data bit.
- Undefined: no parity bit; behaviour is exactly as above.

Decomposition:
- Shared include/package piso_pkg holds:
  - state encodings ST_IDLE=1'b0, ST_SHIFT=1'b1;
  - the default WIDTH/NREQ constants;
  - the clog2 helper function.
- One natural sub-module, rr_arbiter:
  - inputs: req vector, pointer;
  - outputs: one-hot grant and encoded index;
  - purely combinational.
- The shifter and FSM stay in piso_rr_sched.

Test Plan:
- Single word: reset, then req_valid_i=0001 with word0=1011, ready_in=1.
  - Expect req_ready_o=0001 for 1 cycle.
  - Then data_o=1,0,1,1 on 4 consecutive cycles, first_o on bit 1, last_o on bit 4, grant_id_o=0.
  - Then valid_out=0.
- Contention: word0=1011 and word2=0110 valid simultaneously.
  - Expect req0 streamed first, 1 bubble cycle, then 0,1,1,0 with grant_id_o=2.
- Fairness: all 4 requesters held valid for 12 words.
  - Expect grant order 0,1,2,3,0,1,2,3,0,1,2,3.
  - Each word is followed by exactly one idle cycle.
- Backpressure: word 1011, ready_in=0 for 3 cycles after bit 2.
  - Expect data_o=0 and count held for 3 cycles, then bits 1,1 resume.
  - Total SHIFT duration is 7 cycles.
- Reset mid-word: assert rst during bit 3 of word0=1011 while req1 is valid.
  - Expect valid_out=0 immediately.
  - After release, req0 is granted first if valid, else req1; the word is restarted from bit 1.
- PISO_PARITY_EN defined: word 1011.
  - Expect serial 1,0,1,1,1, with last_o on the 5th bit.
  - Word 0110 → 0,1,1,0,0.
